// File: rtl/ram_port_arbiter_if.sv
//-----------------------------------------------------------------------------
// ram_port_arbiter_if
// Bundles the two requester ports and the RAM command/read bus shared through
// ram_port_arbiter.
//
// Signals
//   req0/req1       access request, held by the requester until granted
//   we0/we1         1 = store, 0 = load
//   addr0/addr1     byte address
//   mode0/mode1     00 byte, 01 half-word, 10 word, 11 illegal
//   wdata0/wdata1   right-aligned store data
//   gnt0/gnt1       same-cycle grant
//   rdata0/rdata1   load result, held until the next load response of the port
//   rvalid0/rvalid1 one-cycle load-response pulse
//   ram_addr/ram_mode/ram_we/ram_wdata  registered RAM command
//   ram_rdata       combinational RAM read data
//
// Modports
//   slave  : arbiter view
//   master : requesters plus RAM view
//-----------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        mode0;
    logic [1:0]        mode1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid0;
    logic              rvalid1;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        ram_mode;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, mode0, mode1,
               wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               ram_addr, ram_mode, ram_we, ram_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, mode0, mode1,
               wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
               ram_addr, ram_mode, ram_we, ram_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
//-----------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port data RAM between port 0 (CPU load/store unit) and
// port 1 (debug/display scanner). One request is granted per cycle; the winner
// is registered onto the RAM command bus and load data is captured into a
// per-port response register two cycles after the grant.
//
// Ports
//   clk  system clock
//   clr  synchronous active-high reset
//   bus  ram_port_arbiter_if.slave (requester ports and RAM bus)
//
// Arbitration
//   Default build: port 0 has priority, but after MAX_BURST consecutive port-0
//   grants with port 1 waiting, port 1 wins once.
//   With macro RAM_ARB_ROUND_ROBIN_EN defined: contention goes to the port that
//   did not win last; the burst counter is held at zero.
//-----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              clr,
    ram_port_arbiter_if.slave bus
);

    localparam logic [3:0] LP_MAX_BURST    = 4'(MAX_BURST);
    localparam logic [1:0] LP_MODE_ILLEGAL = 2'b11;

    // Mode 11 is accepted but must neither write nor return RAM data.
    function automatic logic f_mode_legal(input logic [1:0] mode);
        return (mode != LP_MODE_ILLEGAL);
    endfunction

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_pick1;

    logic [3:0]        r_burst_cnt;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic              r_last_winner;
`endif
    logic [ADDR_W-1:0] r_ram_addr;
    logic [1:0]        r_ram_mode;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_ram_wdata;
    // Issue tag: a load is in flight, which port issued it, and whether its
    // data must be forced to zero (illegal mode).
    logic              r_tag_vld;
    logic              r_tag_port;
    logic              r_tag_zero;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;

    // Contention winner: port 1 when the fairness rule says so
`ifdef RAM_ARB_ROUND_ROBIN_EN
    assign w_pick1 = (r_last_winner == 1'b0);
`else
    assign w_pick1 = (r_burst_cnt == LP_MAX_BURST);
`endif

    // Grant decode; nothing is granted while clr is high
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (clr) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (bus.req0 && bus.req1) begin
            w_gnt0 = !w_pick1;
            w_gnt1 = w_pick1;
        end else begin
            w_gnt0 = bus.req0;
            w_gnt1 = bus.req1;
        end
    end

    // Fairness state: burst counter or last winner
    always_ff @(posedge clk) begin
        if (clr) begin
            r_burst_cnt   <= 4'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            r_last_winner <= 1'b1;
`endif
        end else begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            r_burst_cnt <= 4'd0;
            if (w_gnt0) begin
                r_last_winner <= 1'b0;
            end else if (w_gnt1) begin
                r_last_winner <= 1'b1;
            end else begin
                r_last_winner <= r_last_winner;
            end
`else
            // Counts port-0 wins only while port 1 is actually waiting.
            if (!bus.req1 || w_gnt1) begin
                r_burst_cnt <= 4'd0;
            end else if (w_gnt0 && (r_burst_cnt < LP_MAX_BURST)) begin
                r_burst_cnt <= r_burst_cnt + 4'd1;
            end else begin
                r_burst_cnt <= r_burst_cnt;
            end
`endif
        end
    end

    // Issue: register the granted request onto the RAM command bus
    always_ff @(posedge clk) begin
        if (clr) begin
            r_ram_addr  <= {ADDR_W{1'b0}};
            r_ram_mode  <= 2'b00;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= {DATA_W{1'b0}};
            r_tag_vld   <= 1'b0;
            r_tag_port  <= 1'b0;
            r_tag_zero  <= 1'b0;
        end else if (w_gnt0) begin
            r_ram_addr  <= bus.addr0;
            r_ram_mode  <= bus.mode0;
            r_ram_wdata <= bus.wdata0;
            r_ram_we    <= bus.we0 && f_mode_legal(bus.mode0);
            r_tag_vld   <= !bus.we0;
            r_tag_port  <= 1'b0;
            r_tag_zero  <= !f_mode_legal(bus.mode0);
        end else if (w_gnt1) begin
            r_ram_addr  <= bus.addr1;
            r_ram_mode  <= bus.mode1;
            r_ram_wdata <= bus.wdata1;
            r_ram_we    <= bus.we1 && f_mode_legal(bus.mode1);
            r_tag_vld   <= !bus.we1;
            r_tag_port  <= 1'b1;
            r_tag_zero  <= !f_mode_legal(bus.mode1);
        end else begin
            // Idle: address/mode/data hold, nothing is written or tagged.
            r_ram_addr  <= r_ram_addr;
            r_ram_mode  <= r_ram_mode;
            r_ram_wdata <= r_ram_wdata;
            r_ram_we    <= 1'b0;
            r_tag_vld   <= 1'b0;
            r_tag_port  <= r_tag_port;
            r_tag_zero  <= r_tag_zero;
        end
    end

    // Load return: capture RAM read data for the tagged port and pulse rvalid
    always_ff @(posedge clk) begin
        if (clr) begin
            r_rdata0  <= {DATA_W{1'b0}};
            r_rdata1  <= {DATA_W{1'b0}};
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= r_tag_vld && !r_tag_port;
            r_rvalid1 <= r_tag_vld && r_tag_port;
            if (r_tag_vld && !r_tag_port) begin
                r_rdata0 <= r_tag_zero ? {DATA_W{1'b0}} : bus.ram_rdata;
            end else begin
                r_rdata0 <= r_rdata0;
            end
            if (r_tag_vld && r_tag_port) begin
                r_rdata1 <= r_tag_zero ? {DATA_W{1'b0}} : bus.ram_rdata;
            end else begin
                r_rdata1 <= r_rdata1;
            end
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_mode  = r_ram_mode;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
//-----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Drives ram_port_arbiter with directed requester traffic and a behavioural
// byte-array RAM. A reference model (byte memory updated in grant order plus a
// queue of expected load responses) is compared with the DUT every cycle;
// directed literal checks pin the key scenarios.
//-----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    ram_port_arbiter #(.MAX_BURST(MAX_BURST), .ADDR_W(12), .DATA_W(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural RAM (little-endian bytes) ----------------
    logic [7:0] ram_mem [4096];
    logic [7:0] ref_mem [4096];
    logic [7:0] rb0, rb1, rb2, rb3;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        if (bus.ram_we) begin
            case (bus.ram_mode)
                2'b00: ram_mem[bus.ram_addr] <= bus.ram_wdata[7:0];
                2'b01: begin
                    ram_mem[bus.ram_addr]         <= bus.ram_wdata[7:0];
                    ram_mem[bus.ram_addr + 12'd1] <= bus.ram_wdata[15:8];
                end
                2'b10: begin
                    ram_mem[bus.ram_addr]         <= bus.ram_wdata[7:0];
                    ram_mem[bus.ram_addr + 12'd1] <= bus.ram_wdata[15:8];
                    ram_mem[bus.ram_addr + 12'd2] <= bus.ram_wdata[23:16];
                    ram_mem[bus.ram_addr + 12'd3] <= bus.ram_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // Mode 11 reads back the full word here, so a zero response proves the
    // arbiter itself suppresses the data.
    always_comb begin
        rb0 = ram_mem[bus.ram_addr];
        rb1 = ram_mem[bus.ram_addr + 12'd1];
        rb2 = ram_mem[bus.ram_addr + 12'd2];
        rb3 = ram_mem[bus.ram_addr + 12'd3];
        case (bus.ram_mode)
            2'b00:   bus.ram_rdata = {24'h0, rb0};
            2'b01:   bus.ram_rdata = {16'h0, rb1, rb0};
            default: bus.ram_rdata = {rb3, rb2, rb1, rb0};
        endcase
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          port;
        int          due;
        logic [31:0] data;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] m_rdata [2];
    int          m_wins;
    logic        m_last;
    logic        m_ram_we;

    function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] m);
        logic [11:0] a1, a2, a3;
        a1 = a + 12'd1;
        a2 = a + 12'd2;
        a3 = a + 12'd3;
        case (m)
            2'b00:   return {24'h0, ref_mem[a]};
            2'b01:   return {16'h0, ref_mem[a1], ref_mem[a]};
            2'b10:   return {ref_mem[a3], ref_mem[a2], ref_mem[a1], ref_mem[a]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_issue(input int p, input logic we, input logic [11:0] a,
                             input logic [1:0] m, input logic [31:0] d);
        resp_t e;
        if (we) begin
            if (m != 2'b11) begin
                m_ram_we = 1'b1;
                ref_mem[a] = d[7:0];
                if (m != 2'b00) ref_mem[a + 12'd1] = d[15:8];
                if (m == 2'b10) begin
                    ref_mem[a + 12'd2] = d[23:16];
                    ref_mem[a + 12'd3] = d[31:24];
                end
            end
        end else begin
            e.port = p;
            e.due  = cyc + 2;
            e.data = ref_load(a, m);
            rq.push_back(e);
        end
    endtask

    task automatic model_cycle();
        logic [1:0] erv;
        logic       eg0, eg1, pick1;
        erv = 2'b00;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv[rq[0].port]       = 1'b1;
            m_rdata[rq[0].port]   = rq[0].data;
            void'(rq.pop_front());
        end
        chk("rvalid0", 32'(bus.rvalid0), 32'(erv[0]));
        chk("rvalid1", 32'(bus.rvalid1), 32'(erv[1]));
        chk("rdata0", bus.rdata0, m_rdata[0]);
        chk("rdata1", bus.rdata1, m_rdata[1]);
        chk("ram_we", 32'(bus.ram_we), 32'(m_ram_we));

        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!clr) begin
            if (bus.req0 && bus.req1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                pick1 = (m_last == 1'b0);
`else
                pick1 = (m_wins >= MAX_BURST);
`endif
                eg0 = !pick1;
                eg1 = pick1;
            end else begin
                eg0 = bus.req0;
                eg1 = bus.req1;
            end
        end
        chk("gnt0", 32'(bus.gnt0), 32'(eg0));
        chk("gnt1", 32'(bus.gnt1), 32'(eg1));

        // advance model to the next cycle
        if (clr) begin
            rq.delete();
            m_rdata[0] = 32'h0;
            m_rdata[1] = 32'h0;
            m_wins     = 0;
            m_last     = 1'b1;
            m_ram_we   = 1'b0;
        end else begin
            m_ram_we = 1'b0;
            if (eg0) ref_issue(0, bus.we0, bus.addr0, bus.mode0, bus.wdata0);
            else if (eg1) ref_issue(1, bus.we1, bus.addr1, bus.mode1, bus.wdata1);
            if (!bus.req1 || eg1) m_wins = 0;
            else if (eg0 && m_wins < MAX_BURST) m_wins++;
            if (eg0) m_last = 1'b0;
            else if (eg1) m_last = 1'b1;
        end
    endtask

    initial begin
        m_rdata[0] = 32'h0;
        m_rdata[1] = 32'h0;
        m_wins     = 0;
        m_last     = 1'b1;
        m_ram_we   = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input logic r, input logic we, input logic [11:0] a,
                         input logic [1:0] m, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.mode0 = m; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.mode1 = m; bus.wdata1 = d;
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the posedge ending the
    // grant cycle, with the request dropped.
    task automatic access(input int p, input logic we, input logic [11:0] a,
                          input logic [1:0] m, input logic [31:0] d, output int gcyc);
        bit got;
        int n;
        got  = 1'b0;
        n    = 0;
        gcyc = -1;
        drive(p, 1'b1, we, a, m, d);
        while (!got && n < 20) begin
            @(negedge clk);
            got = (p == 0) ? bus.gnt0 : bus.gnt1;
            if (got) gcyc = cyc;
            nxt();
            n++;
        end
        drive(p, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout: port %0d saw no grant, expected one within 20 cycles", p);
        end
    endtask

    task automatic goto_resp(input int g);
        do @(negedge clk); while (cyc < g + 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000 time units");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int       g, g2;
        bit       pend [2];
        bit       granted [2];
        logic [9:0] exp_pat;

        // Reset with both ports requesting
        clr = 1'b1;
        drive(0, 1'b1, 1'b0, 12'h000, 2'b10, 32'h0);
        drive(1, 1'b1, 1'b0, 12'h004, 2'b10, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt0", 32'(bus.gnt0), 32'h0);
            chk("rst_gnt1", 32'(bus.gnt1), 32'h0);
        end
        nxt();
        clr = 1'b0;
        drive(0, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);
        drive(1, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);
        @(negedge clk);
        chk("rst_rvalid0", 32'(bus.rvalid0), 32'h0);
        chk("rst_rvalid1", 32'(bus.rvalid1), 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_rdata0", bus.rdata0, 32'h0);

        // Starvation: both ports held requesting
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_pat = 10'b1010101010;
`else
        exp_pat = 10'b1000010000;
`endif
        nxt();
        drive(0, 1'b1, 1'b0, 12'h100, 2'b10, 32'h0);
        drive(1, 1'b1, 1'b0, 12'h104, 2'b10, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("starve_grant[%0d]", i), {30'h0, bus.gnt1, bus.gnt0},
                {30'h0, exp_pat[i], !exp_pat[i]});
            nxt();
        end
        drive(0, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);
        drive(1, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);

        // Store then back-to-back load of the same word
        access(0, 1'b1, 12'h010, 2'b10, 32'hDEADBEEF, g);
        access(0, 1'b0, 12'h010, 2'b10, 32'h0, g2);
        chk("st_ld_b2b_grant", 32'(g2), 32'(g + 1));
        @(negedge clk);
        chk("st_ld_rvalid0_t1", 32'(bus.rvalid0), 32'h0);
        @(negedge clk);
        chk("st_ld_rvalid0_t2", 32'(bus.rvalid0), 32'h1);
        chk("st_ld_rdata0", bus.rdata0, 32'hDEADBEEF);

        // Sub-word routing
        nxt();
        access(1, 1'b1, 12'h023, 2'b00, 32'h000000AB, g);
        access(0, 1'b0, 12'h020, 2'b10, 32'h0, g);
        goto_resp(g);
        chk("sub_word_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("sub_word_rdata0", bus.rdata0, 32'hAB000000);
        nxt();
        access(1, 1'b0, 12'h022, 2'b01, 32'h0, g);
        goto_resp(g);
        chk("sub_half_rvalid1", 32'(bus.rvalid1), 32'h1);
        chk("sub_half_rdata1", bus.rdata1, 32'h0000AB00);

        // Illegal mode
        nxt();
        access(0, 1'b1, 12'h010, 2'b11, 32'h12345678, g);
        @(negedge clk);
        chk("ill_store_ram_we", 32'(bus.ram_we), 32'h0);
        nxt();
        access(0, 1'b0, 12'h010, 2'b10, 32'h0, g);
        goto_resp(g);
        chk("ill_mem_unchanged", bus.rdata0, 32'hDEADBEEF);
        nxt();
        access(0, 1'b0, 12'h010, 2'b11, 32'h0, g);
        goto_resp(g);
        chk("ill_load_rvalid0", 32'(bus.rvalid0), 32'h1);
        chk("ill_load_rdata0", bus.rdata0, 32'h0);

        // Reset while a port-1 load is in flight
        nxt();
        access(1, 1'b0, 12'h020, 2'b10, 32'h0, g);
        clr = 1'b1;
        nxt();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_mid_rvalid1", 32'(bus.rvalid1), 32'h0);
        chk("clr_mid_rdata1", bus.rdata1, 32'h0);

        // Mixed traffic on both ports, each request held until granted
        nxt();
        pend[0] = 1'b0; pend[1] = 1'b0;
        granted[0] = 1'b0; granted[1] = 1'b0;
        for (int k = 0; k < 80; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && granted[p]) pend[p] = 1'b0;
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        pend[p] = 1'b1;
                        drive(p, 1'b1, 1'($urandom_range(0, 1)),
                              12'h040 + 12'($urandom_range(0, 15)),
                              2'($urandom_range(0, 3)), $urandom);
                    end else begin
                        drive(p, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);
                    end
                end
            end
            @(negedge clk);
            granted[0] = bus.gnt0;
            granted[1] = bus.gnt1;
            nxt();
        end
        drive(0, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);
        drive(1, 1'b0, 1'b0, 12'h000, 2'b00, 32'h0);
        repeat (4) nxt();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
